input_stream_driver: RTL and testbench
======================================

Name: input_stream_driver

Overview:
- Transmitter for the accelerator's 5-lane input stream (input0..input4 with valid/ready), driven by start and reporting running.
- Reads words from a single-port, 1-cycle-latency memory and packs 5 consecutive words per beat.
- Offers beats under a valid/ready handshake until a programmed beat count is sent.
- Sits between the feature-map/kernel memory and the compute core's input port.

Parameters:
- DATA_WIDTH, 16, width of one lane word and one memory word
- ADDR_WIDTH, 16, memory address width; addresses wrap mod 2^ADDR_WIDTH
- CNT_WIDTH, 16, width of beat count and of the optional stall counter

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  pulse; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address, latched on accepted start
- num_beats  in  CNT_WIDTH  beats to send, latched on accepted start
- running  out  1  high from the cycle after an accepted start until the final handshake (or the done pulse for zero beats)
- done  out  1  one-cycle pulse, the cycle after the final handshake
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_WIDTH  memory read address
- mem_rd_data  in  DATA_WIDTH  read data, valid the cycle after mem_rd_en
- input0..input4  out  DATA_WIDTH each  beat lanes
- valid  out  1  beat offered
- ready  in  1  sink accepts the beat when valid && ready
- stall_cycles  out  CNT_WIDTH  only with STREAM_STALL_CNT_EN

Behaviour:
- Reset values: running=0, done=0, valid=0, mem_rd_en=0, mem_addr=0, input0..4=0, stall_cycles=0, state=IDLE. Reset mid-operation aborts immediately and discards any partial beat.
- FSM states: IDLE, FILL, LAST, OFFER, FIN.
- IDLE:
  - start=1 and num_beats!=0: latch base_addr and num_beats; clear lane index k; go to FILL.
  - start=1 and num_beats==0: go to FIN; no memory reads issued.
- FILL (5 cycles, k=0..4):
  - Drive mem_rd_en=1 and mem_addr=ptr+k.
  - For k>=1, capture mem_rd_data into lane k-1.
  - After k=4, go to LAST.
- LAST: mem_rd_en=0; capture lane 4; go to OFFER.
- OFFER:
  - valid=1; lanes are held stable until the handshake.
  - On valid&&ready: ptr+=5 (wraps), decrement remaining.
  - If remaining was 1, go to FIN; otherwise go to FILL.
  - valid drops in the cycle after the handshake.
- FIN: done=1 for one cycle; running=0; go to IDLE.
- Lane mapping: inputN = mem[ptr+N], N=0..4.
- Latency: start accepted at edge 0 → mem_rd_en high cycles 1–5 → valid high from cycle 7. Minimum beat period is 7 cycles (5 FILL + LAST + OFFER).
- start while not IDLE is ignored; base_addr/num_beats changes after acceptance are ignored.
- ready may be high before valid; this has no effect. ready held low stalls indefinitely, with no reads issued while in OFFER.
- Address arithmetic is modulo 2^ADDR_WIDTH; a beat may straddle the wrap (e.g. base 0xFFFE → reads FFFE, FFFF, 0000, 0001, 0002).

Optional Feature:
- Macro: STREAM_STALL_CNT_EN.
- Defined:
  - stall_cycles counts cycles with valid=1 && ready=0 and saturates at all-ones.
  - It clears on an accepted start and holds after done.
- Undefined: the port and counter are absent; no other behaviour changes.

Decomposition:
- Shared package (existing config package): DATA_WIDTH/ADDR_WIDTH defaults, constant LANES=5, and enum stream_state_t {IDLE, FILL, LAST, OFFER, FIN}.
- One natural sub-module: stream_beat_packer, which holds the 5-lane capture registers and the lane index, keeping the FSM and address logic in the top.

Test Plan:
- Memory mem[i]=i, base=0x0010, num_beats=1, ready=1: reads 0x10–0x14 in cycles 1–5; valid at cycle 7 with lanes 16,17,18,19,20; done at cycle 8; running high in cycles 1–7.
- num_beats=3, base=0, ready=1: three beats (0..4, 5..9, 10..14), each valid exactly one cycle, 7 cycles apart; a single done pulse.
- num_beats=2, ready low for 10 cycles during the first OFFER: lanes stable, no mem_rd_en during the stall; second beat is 5..9. With STREAM_STALL_CNT_EN, stall_cycles=10.
- base=0xFFFE, num_beats=1: addresses FFFE, FFFF, 0000, 0001, 0002 in that order.
- num_beats=0 plus start: done pulses at cycle 1; no mem_rd_en; valid never asserts. A start while running is ignored, and the beat count is unchanged.
- rst asserted in FILL: next cycle all outputs are at reset values; a fresh start then streams correctly from the new base.

Source files
------------

// File: rtl/input_stream_driver_pkg.sv
// Shared configuration for the input stream driver: default widths, lane count
// and the FSM state encoding.
package input_stream_driver_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int CNT_WIDTH_DEF  = 16;
  localparam int LANES          = 5;
  localparam int IDX_WIDTH      = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    LAST  = 3'd2,
    OFFER = 3'd3,
    FIN   = 3'd4
  } stream_state_t;

endpackage

// File: rtl/input_stream_driver_stream_beat_packer.sv
// Five-lane capture registers plus the lane index that walks a beat fill.
// Memory data lags the address by one cycle, so lane k-1 is written while index k is current.
module stream_beat_packer
  import input_stream_driver_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_clr_idx,
  input  logic                             i_fill_step,
  input  logic                             i_last_cap,
  input  logic [DATA_WIDTH-1:0]            i_rd_data,
  output logic [IDX_WIDTH-1:0]             o_idx,
  output logic [LANES-1:0][DATA_WIDTH-1:0] o_lanes
);

  logic [IDX_WIDTH-1:0]             r_idx;
  logic [LANES-1:0][DATA_WIDTH-1:0] r_lanes;
  logic [LANES-1:0]                 w_cap;

  // Per-lane capture enables; the final lane is filled during LAST.
  always_comb begin
    w_cap = {LANES{1'b0}};
    for (int n = 0; n < LANES - 1; n++) begin
      if (i_fill_step && (r_idx == IDX_WIDTH'(n + 1))) begin
        w_cap[n] = 1'b1;
      end else begin
        w_cap[n] = 1'b0;
      end
    end
    w_cap[LANES-1] = i_last_cap;
  end

  // Lane index and lane data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= {IDX_WIDTH{1'b0}};
      r_lanes <= {(LANES*DATA_WIDTH){1'b0}};
    end else begin
      if (i_clr_idx) begin
        r_idx <= {IDX_WIDTH{1'b0}};
      end else if (i_fill_step) begin
        r_idx <= r_idx + IDX_WIDTH'(1);
      end else begin
        r_idx <= r_idx;
      end
      for (int n = 0; n < LANES; n++) begin
        if (w_cap[n]) begin
          r_lanes[n] <= i_rd_data;
        end else begin
          r_lanes[n] <= r_lanes[n];
        end
      end
    end
  end

  assign o_idx   = r_idx;
  assign o_lanes = r_lanes;

endmodule

// File: rtl/input_stream_driver.sv
// Streams 5-word beats read from a 1-cycle-latency memory under valid/ready.
// Optional stall counter enabled by defining STREAM_STALL_CNT_EN.
module input_stream_driver
  import input_stream_driver_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [CNT_WIDTH-1:0]  num_beats,
  output logic                  running,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [DATA_WIDTH-1:0] input0,
  output logic [DATA_WIDTH-1:0] input1,
  output logic [DATA_WIDTH-1:0] input2,
  output logic [DATA_WIDTH-1:0] input3,
  output logic [DATA_WIDTH-1:0] input4,
  output logic                  valid,
`ifdef STREAM_STALL_CNT_EN
  output logic [CNT_WIDTH-1:0]  stall_cycles,
`endif
  input  logic                  ready
);

  localparam logic [ADDR_WIDTH-1:0] LP_STEP = ADDR_WIDTH'(LANES);

  stream_state_t                    r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]            r_ptr, w_ptr_nxt;
  logic [CNT_WIDTH-1:0]             r_remaining, w_remaining_nxt;
  logic                             r_mem_rd_en, w_mem_rd_en_nxt;
  logic [ADDR_WIDTH-1:0]            r_mem_addr, w_mem_addr_nxt;
  logic                             r_valid, w_valid_nxt;
  logic                             r_done, w_done_nxt;
  logic                             r_running, w_running_nxt;
  logic                             w_clr_idx, w_fill_step, w_last_cap, w_start_acc;
  logic [IDX_WIDTH-1:0]             w_idx;
  logic [LANES-1:0][DATA_WIDTH-1:0] w_lanes;

  stream_beat_packer #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clr_idx   (w_clr_idx),
    .i_fill_step (w_fill_step),
    .i_last_cap  (w_last_cap),
    .i_rd_data   (mem_rd_data),
    .o_idx       (w_idx),
    .o_lanes     (w_lanes)
  );

  // Next-state and next-output logic; outputs are registered one cycle ahead.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_remaining_nxt = r_remaining;
    w_mem_rd_en_nxt = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_valid_nxt     = 1'b0;
    w_done_nxt      = 1'b0;
    w_running_nxt   = r_running;
    w_clr_idx       = 1'b0;
    w_fill_step     = 1'b0;
    w_last_cap      = 1'b0;
    w_start_acc     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_start_acc = 1'b1;
          w_clr_idx   = 1'b1;
          if (num_beats != {CNT_WIDTH{1'b0}}) begin
            w_state_nxt     = FILL;
            w_ptr_nxt       = base_addr;
            w_remaining_nxt = num_beats;
            w_mem_rd_en_nxt = 1'b1;
            w_mem_addr_nxt  = base_addr;
            w_running_nxt   = 1'b1;
          end else begin
            w_state_nxt = FIN;
            w_done_nxt  = 1'b1;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FILL: begin
        w_fill_step = 1'b1;
        if (w_idx == IDX_WIDTH'(LANES - 1)) begin
          w_state_nxt = LAST;
        end else begin
          w_mem_rd_en_nxt = 1'b1;
          w_mem_addr_nxt  = r_mem_addr + ADDR_WIDTH'(1);
        end
      end
      LAST: begin
        w_last_cap  = 1'b1;
        w_state_nxt = OFFER;
        w_valid_nxt = 1'b1;
      end
      OFFER: begin
        if (r_valid && ready) begin
          w_ptr_nxt       = r_ptr + LP_STEP;
          w_remaining_nxt = r_remaining - CNT_WIDTH'(1);
          if (r_remaining == CNT_WIDTH'(1)) begin
            w_state_nxt   = FIN;
            w_done_nxt    = 1'b1;
            w_running_nxt = 1'b0;
          end else begin
            w_state_nxt     = FILL;
            w_clr_idx       = 1'b1;
            w_mem_rd_en_nxt = 1'b1;
            w_mem_addr_nxt  = r_ptr + LP_STEP;
          end
        end else begin
          w_valid_nxt = 1'b1;
        end
      end
      FIN: begin
        w_state_nxt   = IDLE;
        w_running_nxt = 1'b0;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_running_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= {ADDR_WIDTH{1'b0}};
      r_remaining <= {CNT_WIDTH{1'b0}};
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= {ADDR_WIDTH{1'b0}};
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_running   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_remaining <= w_remaining_nxt;
      r_mem_rd_en <= w_mem_rd_en_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_valid     <= w_valid_nxt;
      r_done      <= w_done_nxt;
      r_running   <= w_running_nxt;
    end
  end

`ifdef STREAM_STALL_CNT_EN
  logic [CNT_WIDTH-1:0] r_stall_cycles;

  // Saturating count of offered-but-refused cycles, cleared per run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= {CNT_WIDTH{1'b0}};
    end else if (w_start_acc) begin
      r_stall_cycles <= {CNT_WIDTH{1'b0}};
    end else if (r_valid && !ready && (r_stall_cycles != {CNT_WIDTH{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

  assign running   = r_running;
  assign done      = r_done;
  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign valid     = r_valid;
  assign input0    = w_lanes[0];
  assign input1    = w_lanes[1];
  assign input2    = w_lanes[2];
  assign input3    = w_lanes[3];
  assign input4    = w_lanes[4];

endmodule

// File: tb/tb_input_stream_driver.sv
// Directed bench for input_stream_driver against a memory model with mem[i]=i.
module tb_input_stream_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] base_addr = 16'd0;
  logic [15:0] num_beats = 16'd0;
  logic        running, done, mem_rd_en, valid;
  logic        ready = 1'b1;
  logic [15:0] mem_addr;
  logic [15:0] mem_rd_data = 16'd0;
  logic [15:0] input0, input1, input2, input3, input4;
`ifdef STREAM_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int t0 = 0;

  int          rd_cyc[$];
  logic [15:0] rd_addr[$];
  int          beat_cyc[$];
  logic [79:0] beat_dat[$];
  int          done_cyc[$];
  int          run_first, run_last, run_cnt;

  input_stream_driver dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .num_beats    (num_beats),
    .running      (running),
    .done         (done),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .input0       (input0),
    .input1       (input1),
    .input2       (input2),
    .input3       (input3),
    .input4       (input4),
    .valid        (valid),
`ifdef STREAM_STALL_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .ready        (ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: word at address i holds i, one-cycle read latency
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem_addr;

  always @(negedge clk) begin
    if (mem_rd_en) begin
      rd_addr.push_back(mem_addr);
      rd_cyc.push_back(cyc - t0);
    end
    if (valid) begin
      beat_dat.push_back({input4, input3, input2, input1, input0});
      beat_cyc.push_back(cyc - t0);
    end
    if (done) done_cyc.push_back(cyc - t0);
    if (running) begin
      if (run_cnt == 0) run_first = cyc - t0;
      run_last = cyc - t0;
      run_cnt++;
    end
  end

  task automatic check_vec(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] exp_beat(input logic [15:0] b);
    logic [15:0] a;
    logic [79:0] r;
    r = 80'd0;
    for (int n = 0; n < 5; n++) begin
      a = b + 16'(n);
      r[16*n +: 16] = a;
    end
    return r;
  endfunction

  // accepted at the next edge ("edge 0"); cycle numbers count from there
  task automatic do_start(input logic [15:0] b, input logic [15:0] nb);
    start = 1'b1;
    base_addr = b;
    num_beats = nb;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0 = cyc - 1;
    rd_cyc.delete();
    rd_addr.delete();
    beat_cyc.delete();
    beat_dat.delete();
    done_cyc.delete();
    run_cnt = 0;
    run_first = 0;
    run_last = 0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_vec({tag, "_ctl"}, {running, done, valid, mem_rd_en}, 80'd0);
    check_vec({tag, "_addr"}, mem_addr, 80'd0);
    check_vec({tag, "_lanes"}, {input4, input3, input2, input1, input0}, 80'd0);
  endtask

  initial begin
    logic [15:0] a;
    run_cycles(3);
    check_reset_outputs("reset");
`ifdef STREAM_STALL_CNT_EN
    check_vec("reset_stall", stall_cycles, 80'd0);
`endif
    rst = 1'b0;
    run_cycles(2);

    // single beat from 0x0010
    do_start(16'h0010, 16'd1);
    run_cycles(12);
    check_vec("t1_rd_count", rd_addr.size(), 80'd5);
    for (int i = 0; i < 5; i++) begin
      check_vec("t1_rd_addr", rd_addr[i], 80'(16'h0010 + i));
      check_vec("t1_rd_cyc", rd_cyc[i], 80'(i + 1));
    end
    check_vec("t1_beat_count", beat_dat.size(), 80'd1);
    check_vec("t1_beat_cyc", beat_cyc[0], 80'd7);
    check_vec("t1_lanes", beat_dat[0], {16'd20, 16'd19, 16'd18, 16'd17, 16'd16});
    check_vec("t1_done_count", done_cyc.size(), 80'd1);
    check_vec("t1_done_cyc", done_cyc[0], 80'd8);
    check_vec("t1_run_span", {16'(run_first), 16'(run_last), 16'(run_cnt)},
              {16'd1, 16'd7, 16'd7});

    // three back-to-back beats
    do_start(16'h0000, 16'd3);
    run_cycles(26);
    check_vec("t2_beat_count", beat_dat.size(), 80'd3);
    for (int b = 0; b < 3; b++) begin
      check_vec("t2_beat_cyc", beat_cyc[b], 80'(7 + 7 * b));
      check_vec("t2_lanes", beat_dat[b], exp_beat(16'(5 * b)));
    end
    check_vec("t2_done_count", done_cyc.size(), 80'd1);
    check_vec("t2_done_cyc", done_cyc[0], 80'd22);

    // ten-cycle stall on the first beat
    ready = 1'b0;
    do_start(16'h0000, 16'd2);
    run_cycles(7);
    for (int i = 0; i < 10; i++) begin
      check_vec("t3_stall_hold", {valid, mem_rd_en, input4, input3, input2, input1, input0},
                {1'b1, 1'b0, exp_beat(16'd0)});
      run_cycles(1);
    end
    ready = 1'b1;
    run_cycles(12);
    check_vec("t3_beat2_lanes", beat_dat[beat_dat.size() - 1], exp_beat(16'd5));
    check_vec("t3_beat2_cyc", beat_cyc[beat_cyc.size() - 1], 80'd24);
    check_vec("t3_done", {16'(done_cyc.size()), 16'(done_cyc[0])}, {16'd1, 16'd25});
    check_vec("t3_rd_count", rd_addr.size(), 80'd10);
`ifdef STREAM_STALL_CNT_EN
    check_vec("t3_stall_cycles", stall_cycles, 80'd10);
`endif

    // beat straddling the address wrap
    do_start(16'hFFFE, 16'd1);
    run_cycles(12);
    check_vec("t4_rd_count", rd_addr.size(), 80'd5);
    a = 16'hFFFE;
    for (int i = 0; i < 5; i++) begin
      check_vec("t4_rd_addr", rd_addr[i], a);
      a = a + 16'd1;
    end
    check_vec("t4_lanes", beat_dat[0], {16'h0002, 16'h0001, 16'h0000, 16'hFFFF, 16'hFFFE});

    // zero beats
    do_start(16'h0030, 16'd0);
    run_cycles(6);
    check_vec("t5_done", {16'(done_cyc.size()), 16'(done_cyc[0])}, {16'd1, 16'd1});
    check_vec("t5_no_reads", rd_addr.size(), 80'd0);
    check_vec("t5_no_valid", beat_dat.size(), 80'd0);

    // start while running is ignored
    do_start(16'h0020, 16'd1);
    run_cycles(3);
    start = 1'b1;
    base_addr = 16'h0100;
    num_beats = 16'd5;
    run_cycles(1);
    start = 1'b0;
    run_cycles(12);
    check_vec("t5_ign_beats", beat_dat.size(), 80'd1);
    check_vec("t5_ign_lanes", beat_dat[0], exp_beat(16'h0020));
    check_vec("t5_ign_done", done_cyc.size(), 80'd1);
    check_vec("t5_ign_reads", rd_addr.size(), 80'd5);

    // reset in FILL, then a fresh run
    do_start(16'h0040, 16'd2);
    run_cycles(3);
    rst = 1'b1;
    run_cycles(1);
    check_reset_outputs("t6_reset");
    rst = 1'b0;
    do_start(16'h0080, 16'd1);
    run_cycles(12);
    check_vec("t6_beats", beat_dat.size(), 80'd1);
    check_vec("t6_lanes", beat_dat[0], exp_beat(16'h0080));
    check_vec("t6_first_addr", rd_addr[0], 80'h0080);
    check_vec("t6_done", done_cyc.size(), 80'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
